// File: rtl/craft_pkg.sv
// Shared CRAFT scheduler constants and the job sequencer state type.
// Widths match the iterative round datapath the scheduler drives.
package craft_pkg;
    localparam int CRAFT_NROUNDS = 32;
    localparam int CRAFT_BLK_W   = 64;
    localparam int CRAFT_TWK_W   = 64;
    localparam int CRAFT_KEY_W   = 128;
    localparam int CRAFT_RND_W   = 5;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        RESP
    } sched_state_e;
endpackage

// File: rtl/craft_rr_arbiter.sv
// Round-robin pick of the first asserted req at or above ptr, wrapping modulo NREQ.
// Purely combinational, zero latency; grant is all-zero when en is low.
module craft_rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx
);
    logic [IDW:0] cand;
    logic         found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            // One spare bit keeps ptr+k from overflowing before the wrap.
            cand = {1'b0, ptr} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (en && !found && req[cand[IDW-1:0]]) begin
                found                = 1'b1;
                gnt[cand[IDW-1:0]]   = 1'b1;
                idx                  = cand[IDW-1:0];
            end
        end
    end
endmodule

// File: rtl/craft_job_sched.sv
// Shares one iterative CRAFT round datapath among NREQ requesters, round-robin.
// Accept to rsp_valid is NROUNDS+1 cycles; rsp_ready low holds RESP and blocks new grants.
module craft_job_sched
    import craft_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int NROUNDS = CRAFT_NROUNDS,
    parameter int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [CRAFT_BLK_W*NREQ-1:0] req_pt,
    input  logic [CRAFT_TWK_W*NREQ-1:0] req_tweak,
    input  logic [CRAFT_KEY_W*NREQ-1:0] req_key,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [IDW-1:0]            rsp_id,
    output logic [CRAFT_BLK_W-1:0]    rsp_ct,
    output logic                      dp_load,
    output logic                      dp_en,
    output logic [CRAFT_RND_W-1:0]    dp_round,
    output logic                      dp_last,
    output logic [CRAFT_BLK_W-1:0]    dp_pt,
    output logic [CRAFT_TWK_W-1:0]    dp_tweak,
    output logic [CRAFT_KEY_W-1:0]    dp_key,
    input  logic [CRAFT_BLK_W-1:0]    dp_state,
    output logic                      busy
);
    sched_state_e             state_q, state_d;
    logic [IDW-1:0]           ptr_q, ptr_d;
    logic [IDW-1:0]           id_q, id_d;
    logic [CRAFT_RND_W-1:0]   cnt_q, cnt_d;
    logic [CRAFT_BLK_W-1:0]   pt_q, pt_d;
    logic [CRAFT_TWK_W-1:0]   tweak_q, tweak_d;
    logic [CRAFT_KEY_W-1:0]   key_q, key_d;
    logic [NREQ-1:0]          arb_gnt;
    logic [IDW-1:0]           arb_idx;
    logic                     accept;
    logic                     last_rnd;

    craft_rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req (req_valid),
        .ptr (ptr_q),
        .en  (state_q == IDLE),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    // The grant already implies req_valid, so any grant is an acceptance.
    assign accept   = |arb_gnt;
    assign last_rnd = (cnt_q == CRAFT_RND_W'(NROUNDS - 1));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        pt_d    = pt_q;
        tweak_d = tweak_q;
        key_d   = key_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = LOAD;
                    id_d    = arb_idx;
                    ptr_d   = (arb_idx == IDW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
                    for (int i = 0; i < NREQ; i++) begin
                        if (arb_gnt[i]) begin
                            pt_d    = req_pt[i*CRAFT_BLK_W +: CRAFT_BLK_W];
                            tweak_d = req_tweak[i*CRAFT_TWK_W +: CRAFT_TWK_W];
                            key_d   = req_key[i*CRAFT_KEY_W +: CRAFT_KEY_W];
                        end
                    end
                end
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (last_rnd) begin
                    cnt_d   = '0;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            pt_q    <= '0;
            tweak_q <= '0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            pt_q    <= pt_d;
            tweak_q <= tweak_d;
            key_q   <= key_d;
        end
    end

    assign req_ready = arb_gnt;
    assign dp_load   = (state_q == LOAD);
    assign dp_en     = (state_q == RUN);
    assign dp_round  = dp_en ? cnt_q : '0;
    assign dp_last   = dp_en & last_rnd;
    assign dp_pt     = pt_q;
    assign dp_tweak  = tweak_q;
    assign dp_key    = key_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = id_q;
    // The datapath holds its state outside LOAD/RUN, so RESP can pass it straight through.
    assign rsp_ct    = rsp_valid ? dp_state : '0;
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_craft_job_sched.sv
// Directed bench for craft_job_sched with a counting datapath stub (load=pt, +1 per round).
module tb_craft_job_sched;
    localparam int NREQ = 2;
    localparam int IDW  = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [64*NREQ-1:0]  req_pt;
    logic [64*NREQ-1:0]  req_tweak;
    logic [128*NREQ-1:0] req_key;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [63:0]       rsp_ct;
    logic              dp_load;
    logic              dp_en;
    logic [4:0]        dp_round;
    logic              dp_last;
    logic [63:0]       dp_pt;
    logic [63:0]       dp_tweak;
    logic [127:0]      dp_key;
    logic [63:0]       dp_state;
    logic              busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    craft_job_sched #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_pt    (req_pt),
        .req_tweak (req_tweak),
        .req_key   (req_key),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_ct    (rsp_ct),
        .dp_load   (dp_load),
        .dp_en     (dp_en),
        .dp_round  (dp_round),
        .dp_last   (dp_last),
        .dp_pt     (dp_pt),
        .dp_tweak  (dp_tweak),
        .dp_key    (dp_key),
        .dp_state  (dp_state),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst)          dp_state <= '0;
        else if (dp_load) dp_state <= dp_pt;
        else if (dp_en)   dp_state <= dp_state + 64'd1;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_grant();
        int n = 0;
        while (req_ready == '0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("grant_timeout", 128'(req_ready != '0), 128'(1));
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rsp_timeout", 128'(rsp_valid), 128'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int acc, prev;
        logic saw;
        logic [127:0] key1;
        logic [63:0]  twk1;
        key1 = 128'h27a6781a43f364bc916708d5fbb5aefe;
        twk1 = 64'h54cd94ffd0670a58;
        rst = 1'b1; req_valid = '0; req_pt = '0; req_tweak = '0; req_key = '0; rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy",  128'(busy), 0);
        check("rst_rdy",   128'(req_ready), 0);
        check("rst_ctl",   128'({rsp_valid, dp_load, dp_en, dp_last, dp_round}), 0);
        check("rst_dat",   128'({dp_pt, rsp_ct, rsp_id}), 0);
        rst = 1'b0;

        // Single job from requester 0
        @(negedge clk);
        req_valid = 2'b01; req_pt[63:0] = 64'h5734F006D8D88A3E;
        #1 check("t1_grant", 128'(req_ready), 128'(2'b01));
        acc = cyc + 1;
        @(negedge clk);
        req_valid = '0;
        #1 check("t1_rdy_drop", 128'(req_ready), 0);
        check("t1_load", 128'({dp_load, dp_en, busy}), 128'(3'b101));
        for (int r = 0; r < 32; r++) begin
            @(negedge clk);
            check("t1_run", 128'({dp_en, dp_load, dp_round, dp_last, rsp_valid}),
                  128'({1'b1, 1'b0, 5'(r), (r == 31), 1'b0}));
        end
        @(negedge clk);
        check("t1_rsp_valid", 128'(rsp_valid), 1);
        check("t1_latency", 128'(cyc - acc), 128'(33));
        check("t1_rsp_id", 128'(rsp_id), 0);
        check("t1_rsp_ct", 128'(rsp_ct), 128'(64'h5734F006D8D88A5E));
        @(negedge clk);
        check("t1_idle", 128'({rsp_valid, busy}), 0);

        // Contention: pointer back to 0 via reset, both requesters held
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req_pt[63:0] = 64'h100; req_pt[127:64] = 64'h200; req_valid = 2'b11;
        #1;
        prev = 0;
        for (int j = 0; j < 4; j++) begin
            wait_grant();
            check("cont_grant", 128'(req_ready), (j % 2 == 0) ? 128'(2'b01) : 128'(2'b10));
            acc = cyc + 1;
            if (j > 0) check("cont_gap", 128'(acc - prev), 128'(35));
            prev = acc;
            @(negedge clk);
            if (j == 3) req_valid = '0;
            wait_rsp();
            check("cont_rsp_id", 128'(rsp_id), 128'(j % 2));
            check("cont_rsp_ct", 128'(rsp_ct), (j % 2 == 0) ? 128'(64'h120) : 128'(64'h220));
        end

        // Backpressure: requester 0 job, requester 1 waiting behind it
        @(negedge clk);
        rsp_ready = 1'b0; req_pt[63:0] = 64'h5000; req_valid = 2'b01;
        #1 wait_grant();
        check("bp_grant", 128'(req_ready), 128'(2'b01));
        @(negedge clk);
        req_valid = 2'b10;
        wait_rsp();
        for (int k = 0; k < 10; k++) begin
            check("bp_hold", 128'({rsp_valid, rsp_id, rsp_ct, req_ready}),
                  128'({1'b1, 1'b0, 64'h5020, 2'b00}));
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1 check("bp_release", 128'({rsp_valid, req_ready}), 128'(3'b100));
        @(negedge clk);
        check("bp_idle", 128'({rsp_valid, busy}), 0);
        check("bp_next_grant", 128'(req_ready), 128'(2'b10));
        @(negedge clk);
        req_valid = '0;
        check("bp_next_load", 128'({dp_load, busy}), 128'(2'b11));

        // Withdrawn request during a busy job
        repeat (5) @(negedge clk);
        req_valid = 2'b10;
        saw = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (req_ready != '0) saw = 1'b1;
        end
        req_valid = '0;
        check("wd_no_ready", 128'(saw), 0);
        wait_rsp();
        check("wd_rsp", 128'({rsp_id, rsp_ct}), 128'({1'b1, 64'h220}));
        @(negedge clk);
        check("wd_idle", 128'({busy, req_ready}), 0);
        req_valid = 2'b11;
        #1 check("wd_ptr_kept", 128'(req_ready), 128'(2'b01));

        // Reset mid-RUN at round 12
        @(negedge clk);
        req_valid = '0;
        begin
            int n = 0;
            while (!(dp_en && dp_round == 5'd12) && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        check("rst_reach_r12", 128'({dp_en, dp_round}), 128'({1'b1, 5'd12}));
        rst = 1'b1;
        #1 check("rst_mid_ctl", 128'({busy, dp_en, dp_load, dp_round, rsp_valid, req_ready}), 0);
        check("rst_mid_dat", 128'({dp_pt, rsp_id}), 0);
        @(negedge clk);
        rst = 1'b0;
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (rsp_valid || busy) saw = 1'b1;
        end
        check("rst_no_rsp", 128'(saw), 0);
        req_valid = 2'b11;
        #1 check("rst_ptr_zero", 128'(req_ready), 128'(2'b01));

        // Requester 1 alone; key/tweak must stay as accepted
        req_pt[127:64] = 64'h777; req_tweak[127:64] = twk1; req_key[255:128] = key1;
        req_valid = 2'b10;
        #1 check("kt_grant", 128'(req_ready), 128'(2'b10));
        @(negedge clk);
        req_valid = '0; req_key[255:128] = ~key1; req_tweak[127:64] = ~twk1;
        #1 check("kt_load_key", dp_key, key1);
        check("kt_load_twk", 128'(dp_tweak), 128'(twk1));
        check("kt_load_pt", 128'({dp_load, dp_pt}), 128'({1'b1, 64'h777}));
        wait_rsp();
        check("kt_rsp_key", dp_key, key1);
        check("kt_rsp_twk", 128'(dp_tweak), 128'(twk1));
        check("kt_rsp", 128'({rsp_id, rsp_ct}), 128'({1'b1, 64'h797}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
